// File: rtl/sp_ram_core_if.sv
// Bus bundle for sp_ram_core: write data, shared address, write enable
// and read data. master drives data/addr/we and samples q; slave is the RAM.
interface sp_ram_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] q;

  modport master (
    output data,
    output addr,
    output we,
    input  q
  );

  modport slave (
    input  data,
    input  addr,
    input  we,
    output q
  );
endinterface

// File: rtl/sp_ram_core.sv
// sp_ram_core: single-port synchronous RAM, 2**ADDR_W x DATA_W, write-first.
// Ports (positional order): data (wr data), addr (shared word address),
//   we (write enable), clk, q (registered read data), rst (sync, active-high,
//   pulled low when left unconnected).
// Macro SP_RAM_OUTREG_EN adds an output pipeline register (latency 2).
module sp_ram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              clk,
  output logic [DATA_W-1:0] q,
  input  tri0               rst
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en;
  logic [DATA_W-1:0] rd;

  // Array is never reset; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[addr] <= data;
    end
  end

  // Registered address: reading the array through addr_q after the
  // same edge that wrote it yields the new word (write-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rd_en  <= 1'b0;
    end else begin
      addr_q <= addr;
      rd_en  <= 1'b1;
    end
  end

  // rd_en acts as the clear of the output register: after reset q is 0
  // until the first normal edge, regardless of what mem[0] holds.
  assign rd = rd_en ? mem[addr_q] : '0;

`ifdef SP_RAM_OUTREG_EN
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= rd;
    end
  end

  assign q = out_q;
`else
  assign q = rd;
`endif

endmodule

// File: tb/tb_sp_ram_core.sv
// Self-checking bench for sp_ram_core: reference memory model feeds a
// queue of expected q values, compared LAT cycles later on falling edges.
module tb_sp_ram_core;

`ifdef SP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sp_ram_core_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  sp_ram_core #(.DATA_W(32), .ADDR_W(10)) dut (
    .data (bus.data),
    .addr (bus.addr),
    .we   (bus.we),
    .clk  (clk),
    .q    (bus.q),
    .rst  (rst)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] mem_m [1024];
  bit          wr_m  [1024];
  logic [31:0] r_val [32];
  int          errors = 0;
  int          checks = 0;

  // One cycle: drive at the current falling edge, model the edge, then
  // compare at the next falling edge against the entry LAT cycles old.
  task automatic cycle(input bit r, input bit w, input logic [9:0] a,
                       input logic [31:0] d, input string tag);
    exp_t e;
    exp_t got;
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.data = d;
    if (r) begin
      sb.delete();
      for (int k = 0; k < LAT; k++) begin
        e.chk = 1'b1;
        e.v   = '0;
        sb.push_back(e);
      end
    end else begin
      if (w) begin
        mem_m[a] = d;
        wr_m[a]  = 1'b1;
        e.chk    = 1'b1;
        e.v      = d;
      end else begin
        e.chk = wr_m[a];
        e.v   = mem_m[a];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (sb.size() >= LAT) begin
      got = sb.pop_front();
      if (got.chk) begin
        checks++;
        assert (bus.q === got.v) else begin
          errors++;
          $error("FAIL %s: q=%h expected=%h", tag, bus.q, got.v);
        end
      end
    end
  endtask

  initial begin
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    for (int i = 0; i < 32; i++) r_val[i] = $urandom;
    @(negedge clk);

    cycle(1'b1, 1'b0, 10'd0, 32'd0, "reset");
    cycle(1'b1, 1'b0, 10'd0, 32'd0, "reset2");

    cycle(1'b0, 1'b1, 10'd0, 32'h0000_00FF, "write_first");

    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 10'(i), r_val[i], "fill_wr");
      cycle(1'b0, 1'b0, 10'(i), 32'hFFFF_FFFF, "fill_hold");
    end

    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 10'(i), 32'h5555_5555, "readback");
    end

    cycle(1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, "ovw_1");
    cycle(1'b0, 1'b1, 10'h3FF, 32'h1234_5678, "ovw_2");
    cycle(1'b0, 1'b0, 10'd7,   32'd0,         "ovw_other");
    cycle(1'b0, 1'b0, 10'h3FF, 32'd0,         "ovw_read");

    cycle(1'b1, 1'b1, 10'd5, 32'hAAAA_AAAA, "reset_mid");
    cycle(1'b0, 1'b0, 10'd5, 32'd0,         "post_rst_5");
    cycle(1'b0, 1'b0, 10'h3FF, 32'd0,       "post_rst_3ff");
    cycle(1'b0, 1'b0, 10'd31, 32'd0,        "post_rst_31");

    // Flush the pipeline so every queued expectation is compared.
    for (int k = 1; k < LAT; k++) begin
      cycle(1'b0, 1'b0, 10'd0, 32'd0, "flush");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_core.md
# sp_ram_core

Single-port synchronous RAM, 1024 words × 32 bits, with one shared address port for read and write. It is the golden behavioural memory used for post-route equivalence checks against fabric-mapped RAM netlists. It is also a generic on-chip scratch buffer. Read data is registered, and writes are write-first: a written word appears on `q` in the same cycle it is written.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits.
- `ADDR_W`, 10: address width; depth = 2**ADDR_W = 1024 words.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `data`, input, DATA_W: write data.
- `addr`, input, ADDR_W: word address, shared by read and write.
- `we`, input, 1: write enable, active-high.
- `q`, output, DATA_W: registered read data.

Positional port order for instantiation: `data, addr, we, clk, q, rst`. The existing 5-port positional instances leave `rst` unconnected. With `rst` unconnected, it must behave as 0; implement with a pull-down or a `tri0` declaration.

## Operation
- Storage: 1024 × 32 array. Contents are not reset and are undefined (X in simulation) until written.
- Each rising edge with `rst`=0 samples `addr` into an internal address register `addr_q`.
- Write: if `we`=1 at the edge, `mem[addr] <= data`.
- Read: `q` = `mem[addr_q]`. Because `addr_q` is registered and the array is updated at the same edge, `q` shows the newly written word after a write. This is write-first behaviour.
- Back-to-back writes to the same address: the last write wins, and `q` tracks each new value.
- The address is always in range; no wrap or overflow handling is needed.
- With `we`=0, the array is unchanged, and `q` follows reads of the registered address.
- Reset: at an edge with `rst`=1:
  - `addr_q` and the output register are cleared, so `q` reads 0.
  - A write requested in that cycle is suppressed.
  - Array contents are retained.
- Reset mid-operation: after `rst` deasserts, the next edge resumes normal sampling. Previously written data is still readable.

## Timing
- Write latency: 1 edge. Data written at edge N is readable on `q` after edge N.
- Read latency: 1 edge. Address presented before edge N yields `q` valid after edge N, stable until the next edge.
- `q` reset value: 0, valid after the first `rst`=1 edge.
- There is no handshake; the RAM accepts one operation per cycle, every cycle.
- Inputs must be stable around the rising edge. Benches drive on the falling edge and compare on the following falling edge.

## Configuration
- Macro `SP_RAM_OUTREG_EN`:
  - Defined: an extra output pipeline register is placed after the array read. Read and write-visible latency becomes 2 edges. This register is cleared to 0 by `rst` and holds its value otherwise.
  - Undefined (default): latency is 1 edge, as described above.
- Write-first semantics are preserved in both modes.

## Test plan
1. **Write-first.** Set `rst`=0, `we`=1, `addr`=0, `data`=0x000000FF, and apply one edge. Required: `q`=0x000000FF.
2. **Sequential fill.** For i=0..31, write a random value R[i] at `addr`=i with `we`=1, one write every two cycles. Required: after each write edge, `q`=R[i].
3. **Readback.** With `we`=0, step `addr` 0..31. Required: one edge after each address, `q`=R[i]. Include address 0, which was overwritten after test 1.
4. **Same-address overwrite.** At `addr`=0x3FF, write 0xDEADBEEF then 0x12345678 on consecutive edges. Required: `q`=0xDEADBEEF, then 0x12345678. A later read returns 0x12345678.
5. **Reset.** With `rst`=1 for one edge while `we`=1, `addr`=5, `data`=0xAAAAAAAA:
   - Required: `q`=0 after that edge.
   - Then read `addr`=5 with `rst`=0 and `we`=0. Required: the prior R[5], not 0xAAAAAAAA.
6. **`SP_RAM_OUTREG_EN` defined.** Repeat tests 1–3. Required: each expected `q` value appears one edge later than listed above.
